// File: rtl/lcd_nibble_engine.sv
// HD44780 4-bit write-only physical layer: power-up init, nibble strobes and post-command delays.
// Define LCD_CMD_FIFO_EN to place a 4-entry request FIFO in front of the engine.
module lcd_nibble_engine #(
    parameter int T_PWRUP = 750000,
    parameter int T_SU    = 2,
    parameter int T_EH    = 12,
    parameter int T_HD    = 2,
    parameter int T_NIB   = 50,
    parameter int T_BYTE  = 2000,
    parameter int T_LONG  = 82000,
    parameter int T_INIT1 = 205000,
    parameter int T_INIT2 = 5000
) (
    input  logic       clk_in,
    input  logic       clear,
    input  logic       wr_valid,
    input  logic       wr_rs,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    output logic       init_done,
    output logic [3:0] lcd_dataout,
    output logic [2:0] lcd_control
);

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int T_MAX = max_of(max_of(max_of(T_PWRUP, T_LONG), max_of(T_INIT1, T_INIT2)),
                                  max_of(max_of(T_BYTE, T_NIB), max_of(T_EH, max_of(T_SU, T_HD))));
    localparam int CW = $clog2(T_MAX + 1);

    typedef enum logic [2:0] {
        S_PWRUP, S_SETUP, S_EHIGH, S_HOLD, S_GAP, S_WAIT, S_IDLE
    } state_t;

    // Steps 0-3 are lone high nibbles (8-bit to 4-bit switch), 4-7 are full configuration bytes.
    function automatic logic [7:0] init_word(input logic [2:0] step);
        case (step)
            3'd0, 3'd1, 3'd2: return 8'h30;
            3'd3:             return 8'h20;
            3'd4:             return 8'h28;
            3'd5:             return 8'h06;
            3'd6:             return 8'h0C;
            default:          return 8'h01;
        endcase
    endfunction

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          cur_rs, rs_n;
    logic [7:0]    cur_byte, byte_n;
    logic          lo_phase, lo_n;
    logic          single_nib, single_n;
    logic [2:0]    init_step, step_n;
    logic          done_n;
    logic          launch;
    logic [2:0]    launch_step;
    int            wait_cycles;
    logic          e_q, rs_q;
    logic [3:0]    data_q;
    logic          req_valid, req_rs, take;
    logic [7:0]    req_data;

    assign take = (state == S_IDLE) && init_done && req_valid;

`ifdef LCD_CMD_FIFO_EN
    logic [8:0] fifo_mem [4];
    logic [1:0] wr_ptr, rd_ptr;
    logic [2:0] fifo_cnt;
    logic       push;

    // A pop in the same cycle frees the slot, so a full FIFO can still take a push.
    assign wr_ready  = !clear && ((fifo_cnt != 3'd4) || take);
    assign push      = wr_valid && wr_ready;
    assign req_valid = (fifo_cnt != 3'd0);
    assign {req_rs, req_data} = fifo_mem[rd_ptr];

    // NOTE: the storage array is not reset; clearing the pointers and count is enough because empty slots are never read.
    always_ff @(posedge clk_in) begin
        if (push) fifo_mem[wr_ptr] <= {wr_rs, wr_data};
    end

    always_ff @(posedge clk_in) begin
        if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (take) rd_ptr <= rd_ptr + 2'd1;
            fifo_cnt <= fifo_cnt + {2'b00, push} - {2'b00, take};
        end
    end
`else
    assign wr_ready  = (state == S_IDLE) && init_done;
    assign req_valid = wr_valid;
    assign req_rs    = wr_rs;
    assign req_data  = wr_data;
`endif

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_n     = state;
        cnt_n       = (cnt != '0) ? cnt - 1'b1 : cnt;
        rs_n        = cur_rs;
        byte_n      = cur_byte;
        lo_n        = lo_phase;
        single_n    = single_nib;
        step_n      = init_step;
        done_n      = init_done;
        launch      = 1'b0;
        launch_step = init_step;

        if (single_nib)
            wait_cycles = (init_step == 3'd0) ? T_INIT1 : (init_step == 3'd1) ? T_INIT2 : T_BYTE;
        else if (!cur_rs && (cur_byte inside {8'h01, 8'h02, 8'h03}))
            wait_cycles = T_LONG;
        else
            wait_cycles = T_BYTE;

        case (state)
            // The counter comes out of reset at zero, so the first PWRUP cycle loads it.
            S_PWRUP: begin
                if (cnt == '0) cnt_n = CW'(T_PWRUP);
                else if (cnt == CW'(1)) begin
                    launch      = 1'b1;
                    launch_step = 3'd0;
                end
            end
            S_SETUP: if (cnt == '0) begin
                state_n = S_EHIGH;
                cnt_n   = CW'(T_EH - 1);
            end
            S_EHIGH: if (cnt == '0) begin
                state_n = S_HOLD;
                cnt_n   = CW'(T_HD - 1);
            end
            S_HOLD: if (cnt == '0) begin
                if (lo_phase || single_nib) begin
                    state_n = S_WAIT;
                    cnt_n   = CW'(wait_cycles - 1);
                end else begin
                    state_n = S_GAP;
                    cnt_n   = CW'(T_NIB - 1);
                end
            end
            S_GAP: if (cnt == '0) begin
                state_n = S_SETUP;
                cnt_n   = CW'(T_SU - 1);
                lo_n    = 1'b1;
            end
            S_WAIT: if (cnt == '0) begin
                if (init_done) state_n = S_IDLE;
                else if (init_step == 3'd7) begin
                    state_n = S_IDLE;
                    done_n  = 1'b1;
                end else begin
                    launch      = 1'b1;
                    launch_step = init_step + 3'd1;
                end
            end
            S_IDLE: if (take) begin
                state_n  = S_SETUP;
                cnt_n    = CW'(T_SU - 1);
                rs_n     = req_rs;
                byte_n   = req_data;
                lo_n     = 1'b0;
                single_n = 1'b0;
            end
            default: state_n = S_PWRUP;
        endcase

        if (launch) begin
            state_n  = S_SETUP;
            cnt_n    = CW'(T_SU - 1);
            rs_n     = 1'b0;
            byte_n   = init_word(launch_step);
            lo_n     = 1'b0;
            single_n = ~launch_step[2];
            step_n   = launch_step;
        end
    end

    always_ff @(posedge clk_in) begin
        if (clear) begin
            state      <= S_PWRUP;
            cnt        <= '0;
            cur_rs     <= 1'b0;
            cur_byte   <= '0;
            lo_phase   <= 1'b0;
            single_nib <= 1'b0;
            init_step  <= '0;
            init_done  <= 1'b0;
            e_q        <= 1'b0;
            rs_q       <= 1'b0;
            data_q     <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            cur_rs     <= rs_n;
            cur_byte   <= byte_n;
            lo_phase   <= lo_n;
            single_nib <= single_n;
            init_step  <= step_n;
            init_done  <= done_n;
            e_q        <= (state_n == S_EHIGH);
            // Bus values change only on entry to SETUP and are held through strobe, gap and idle.
            if (state_n == S_SETUP) begin
                rs_q   <= rs_n;
                data_q <= lo_n ? byte_n[3:0] : byte_n[7:4];
            end
        end
    end

    assign lcd_dataout = data_q;
    assign lcd_control = {e_q, 1'b0, rs_q};

endmodule

// File: tb/tb_lcd_nibble_engine.sv
// Self-checking bench for lcd_nibble_engine: cycle-level waveform model plus literal timing checks.
module tb_lcd_nibble_engine;

    localparam int T_PWRUP = 20, T_SU = 2, T_EH = 4, T_HD = 2, T_NIB = 5;
    localparam int T_BYTE = 10, T_LONG = 40, T_INIT1 = 30, T_INIT2 = 15;

    logic       clk_in = 1'b0;
    logic       clear = 1'b1;
    logic       wr_valid = 1'b0;
    logic       wr_rs = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_ready, init_done;
    logic [3:0] lcd_dataout;
    logic [2:0] lcd_control;

    always #5 clk_in = ~clk_in;

    lcd_nibble_engine #(
        .T_PWRUP(T_PWRUP), .T_SU(T_SU), .T_EH(T_EH), .T_HD(T_HD), .T_NIB(T_NIB),
        .T_BYTE(T_BYTE), .T_LONG(T_LONG), .T_INIT1(T_INIT1), .T_INIT2(T_INIT2)
    ) dut (
        .clk_in(clk_in), .clear(clear), .wr_valid(wr_valid), .wr_rs(wr_rs), .wr_data(wr_data),
        .wr_ready(wr_ready), .init_done(init_done), .lcd_dataout(lcd_dataout), .lcd_control(lcd_control)
    );

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Expected bus state for one clock cycle.
    typedef struct packed {
        logic       e;
        logic       rs;
        logic [3:0] d;
        logic       rdy;
        logic       idn;
    } bus_t;

    bus_t       exp_q[$];
    bus_t       cur;
    logic       m_done, m_pend, tail_rs;
    logic [3:0] tail_d;

    task automatic push_cycles(input int n, input logic e);
        for (int i = 0; i < n; i++)
            exp_q.push_back('{e: e, rs: tail_rs, d: tail_d, rdy: 1'b0, idn: m_done});
    endtask

    task automatic push_nib(input logic rs, input logic [3:0] nib);
        tail_rs = rs;
        tail_d  = nib;
        push_cycles(T_SU, 1'b0);
        push_cycles(T_EH, 1'b1);
        push_cycles(T_HD, 1'b0);
    endtask

    task automatic push_byte(input logic rs, input logic [7:0] b);
        push_nib(rs, b[7:4]);
        push_cycles(T_NIB, 1'b0);
        push_nib(rs, b[3:0]);
        push_cycles((!rs && b >= 8'h01 && b <= 8'h03) ? T_LONG : T_BYTE, 1'b0);
    endtask

    // The cycle right after the reset edge is already part of power-up; T_PWRUP more follow.
    task automatic model_reset();
        exp_q.delete();
        m_done  = 1'b0;
        m_pend  = 1'b1;
        tail_rs = 1'b0;
        tail_d  = 4'h0;
        push_cycles(T_PWRUP, 1'b0);
        push_nib(1'b0, 4'h3); push_cycles(T_INIT1, 1'b0);
        push_nib(1'b0, 4'h3); push_cycles(T_INIT2, 1'b0);
        push_nib(1'b0, 4'h3); push_cycles(T_BYTE, 1'b0);
        push_nib(1'b0, 4'h2); push_cycles(T_BYTE, 1'b0);
        push_byte(1'b0, 8'h28);
        push_byte(1'b0, 8'h06);
        push_byte(1'b0, 8'h0C);
        push_byte(1'b0, 8'h01);
    endtask

    // Model advance and per-cycle comparison.
    initial begin
        logic accept;
        cur = '0;
        m_done = 1'b0;
        m_pend = 1'b0;
        tail_rs = 1'b0;
        tail_d = 4'h0;
        forever begin
            @(posedge clk_in);
            cyc++;
            accept = wr_valid && cur.rdy && !clear;
            if (clear) begin
                model_reset();
                cur = '0;
            end else begin
                if (accept) push_byte(wr_rs, wr_data);
                if (exp_q.size() > 0) cur = exp_q.pop_front();
                else begin
                    if (m_pend) begin
                        m_pend = 1'b0;
                        m_done = 1'b1;
                    end
                    cur = '{e: 1'b0, rs: tail_rs, d: tail_d, rdy: m_done, idn: m_done};
                end
            end
            #1;
            check("bus{E,RW,RS,data,ready,init_done}",
                  {23'd0, lcd_control, lcd_dataout, wr_ready, init_done},
                  {23'd0, cur.e, 1'b0, cur.rs, cur.d, cur.rdy, cur.idn});
        end
    end

    // Strobe and ready-edge log, sampled on the falling edge.
    int         rise_t[$], fall_t[$], rdy_t[$];
    logic [3:0] p_nib[$];
    logic       p_rs[$];
    logic       pe = 1'b0, pr = 1'b0;

    initial forever begin
        @(negedge clk_in);
        if (lcd_control[2] === 1'b1 && pe !== 1'b1) begin
            rise_t.push_back(cyc);
            p_nib.push_back(lcd_dataout);
            p_rs.push_back(lcd_control[0]);
        end
        if (lcd_control[2] === 1'b0 && pe === 1'b1) fall_t.push_back(cyc);
        if (wr_ready === 1'b1 && pr !== 1'b1) rdy_t.push_back(cyc);
        pe = lcd_control[2];
        pr = wr_ready;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic send(input logic rs, input logic [7:0] d);
        int guard;
        guard = 0;
        wr_valid = 1'b1;
        wr_rs    = rs;
        wr_data  = d;
        while (!wr_ready && guard < 500) begin
            @(negedge clk_in);
            guard++;
        end
        check("accept_ready", wr_ready, 1'b1);
        @(negedge clk_in);
        wr_valid = 1'b0;
        wr_data  = 8'($urandom);
    endtask

    task automatic wait_ready(input string name);
        int guard;
        guard = 0;
        while (!wr_ready && guard < 500) begin
            @(negedge clk_in);
            guard++;
        end
        check(name, wr_ready, 1'b1);
    endtask

    task automatic wait_init();
        int guard;
        guard = 0;
        while (!init_done && guard < 1000) begin
            @(negedge clk_in);
            guard++;
        end
        check("init_done_reached", init_done, 1'b1);
    endtask

    logic [3:0] init_nibs [12] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'h6, 4'h0, 4'hC, 4'h0, 4'h1};

    initial begin
        int rel, rb, fb, guard;

        clear = 1'b1;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        check("reset_outputs", {lcd_control, lcd_dataout, wr_ready, init_done}, 10'd0);

        // Power-up and init sequence.
        rb = rise_t.size();
        fb = fall_t.size();
        clear = 1'b0;
        rel = cyc;
        wait_init();
        check("init_pulse_count", rise_t.size() - rb, 12);
        if (rise_t.size() >= rb + 12 && fall_t.size() >= fb + 12) begin
            check("first_e_rise", rise_t[rb] - rel, 23);
            for (int i = 0; i < 12; i++) begin
                check($sformatf("init_nibble%0d", i), p_nib[rb + i], init_nibs[i]);
                check($sformatf("init_rs%0d", i), p_rs[rb + i], 1'b0);
                check($sformatf("init_e_width%0d", i), fall_t[fb + i] - rise_t[rb + i], 4);
            end
            check("init_done_after_long", rdy_t[$] - fall_t[fb + 11], 42);
        end

        // Data byte 0x41.
        @(negedge clk_in);
        rb = rise_t.size();
        fb = fall_t.size();
        send(1'b1, 8'h41);
        wait_ready("ready_after_0x41");
        check("byte41_pulses", rise_t.size() - rb, 2);
        if (rise_t.size() >= rb + 2 && fall_t.size() >= fb + 2) begin
            check("byte41_hi", {p_rs[rb], p_nib[rb]}, 5'h14);
            check("byte41_lo", {p_rs[rb + 1], p_nib[rb + 1]}, 5'h11);
            check("byte41_gap", rise_t[rb + 1] - fall_t[fb], 9);
            check("byte41_post", rdy_t[$] - fall_t[fb + 1], 12);
        end

        // Clear command versus data byte of the same value.
        fb = fall_t.size();
        send(1'b0, 8'h01);
        wait_ready("ready_after_clear_cmd");
        if (fall_t.size() >= fb + 2) check("clear_cmd_post", rdy_t[$] - fall_t[fb + 1], 42);
        fb = fall_t.size();
        send(1'b1, 8'h01);
        wait_ready("ready_after_data01");
        if (fall_t.size() >= fb + 2) check("data01_post", rdy_t[$] - fall_t[fb + 1], 12);

        // Randomised traffic; valid is held across busy periods.
        for (int i = 0; i < 40; i++) begin
            logic       rs;
            logic [7:0] d;
            repeat ($urandom_range(0, 3)) @(negedge clk_in);
            rs = 1'($urandom);
            d  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom);
            send(rs, d);
        end
        wait_ready("ready_after_random");

        // Reset in the middle of an E pulse.
        send(1'b1, 8'h5A);
        guard = 0;
        while (!lcd_control[2] && guard < 100) begin
            @(negedge clk_in);
            guard++;
        end
        check("e_high_before_clear", lcd_control[2], 1'b1);
        clear = 1'b1;
        @(posedge clk_in);
        #1;
        check("abort_e", lcd_control[2], 1'b0);
        check("abort_ready", wr_ready, 1'b0);
        check("abort_init_done", init_done, 1'b0);
        @(negedge clk_in);
        clear = 1'b0;
        rel = cyc;
        rb = rise_t.size();
        wait_init();
        if (rise_t.size() > rb) begin
            check("restart_first_e_rise", rise_t[rb] - rel, 23);
            check("restart_first_nibble", p_nib[rb], 4'h3);
        end

        for (int i = 0; i < 5; i++) send(1'($urandom), 8'($urandom));
        wait_ready("ready_final");
        repeat (3) @(negedge clk_in);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lcd_nibble_engine.md
Name: lcd_nibble_engine

Overview:
- Physical-layer driver for the HD44780-compatible character LCD, in 4-bit write-only mode.
- Sits directly downstream of the LCD data formatter: takes {rs, byte} write requests over a valid/ready handshake.
- Splits each request into high and low nibbles, generates the E strobe with the required setup/pulse/hold timing, and enforces post-command delays.
- Runs the power-up init sequence autonomously after reset, before accepting any request.

Parameters:
- T_PWRUP, 750000, cycles to wait after reset before the first init nibble (15 ms at 50 MHz).
- T_SU, 2, cycles that RS/data are valid before E rises.
- T_EH, 12, cycles E is held high.
- T_HD, 2, cycles RS/data are held after E falls.
- T_NIB, 50, cycles between the high and low nibble of one byte (1 us).
- T_BYTE, 2000, cycles after a normal byte (40 us).
- T_LONG, 82000, cycles after a clear (0x01) or home (0x02/0x03) command with rs=0 (1.64 ms).
- T_INIT1, 205000, cycles after the first 0x3 init nibble (4.1 ms).
- T_INIT2, 5000, cycles after the second 0x3 init nibble (100 us).

Ports:
- clk_in  input  1  system clock, single domain.
- clear  input  1  synchronous reset, active-high.
- wr_valid  input  1  write request present.
- wr_rs  input  1  register select: 0 = command, 1 = data.
- wr_data  input  8  byte to write.
- wr_ready  output  1  engine can accept a request this cycle.
- init_done  output  1  init sequence complete; sticky until reset.
- lcd_dataout  output  4  LCD DB7..DB4.
- lcd_control  output  3  [2]=E, [1]=RW, [0]=RS.

Behaviour:
- Reset (clear=1 at a clk_in edge):
  - All outputs 0: lcd_dataout=0, E=0, RW=0, RS=0, wr_ready=0, init_done=0.
  - State goes to PWRUP and the delay counter is cleared.
  - Reset mid-transfer aborts immediately; E drops on the same edge.
- RW is tied to 0 at all times (write-only).
- Delay counter: one down-counter, width sized for the largest parameter. A wait of N cycles means exactly N clk_in cycles spent in that state.
- Init sequence, all with RS=0:
  - PWRUP waits T_PWRUP.
  - Nibble 0x3, wait T_INIT1; nibble 0x3, wait T_INIT2; nibble 0x3, wait T_BYTE; nibble 0x2, wait T_BYTE.
  - Then full bytes 0x28, 0x06, 0x0C, 0x01, using normal byte timing and post-delays (T_LONG after 0x01).
  - Then init_done=1 and state IDLE.
- Nibble strobe (shared by init and normal traffic):
  - SETUP: drive RS and data for T_SU cycles with E=0.
  - EHIGH: E=1 for T_EH cycles.
  - HOLD: E=0 with data held for T_HD cycles.
- Byte transfer:
  - High nibble strobe, then GAP for T_NIB cycles.
  - Low nibble strobe, then WAIT.
  - WAIT lasts T_LONG if rs=0 and data is 0x01, 0x02 or 0x03; otherwise T_BYTE.
- Handshake:
  - wr_ready=1 only in IDLE with init_done=1.
  - A transfer is accepted on a clk_in edge where wr_valid and wr_ready are both 1; rs/data are latched that edge and wr_ready drops the next cycle.
  - wr_valid while not ready is ignored; the requester must hold it.
  - After WAIT completes the engine returns to IDLE and wr_ready=1 on the following cycle.
  - Minimum accept-to-accept spacing: 2*(T_SU+T_EH+T_HD)+T_NIB+T_BYTE+1 cycles.
- lcd_dataout holds the last driven nibble while idle; E is never high outside EHIGH.
- Parameters of 0 are illegal; the behaviour for them is undefined.

Optional Feature:
- Macro LCD_CMD_FIFO_EN.
- When defined:
  - A 4-entry 9-bit FIFO sits in front of the engine.
  - wr_ready reflects "FIFO not full", and is 0 while clear=1.
  - Requests are accepted during init and during transfers; the engine pops the FIFO in IDLE after init.
  - Ordering is strictly preserved.
  - Push while full is blocked by wr_ready=0.
  - Simultaneous push and pop on a full FIFO is allowed and the count stays at 4.
  - clear empties the FIFO.
- When undefined: no FIFO; the direct handshake above applies.

Test Plan:
- Set parameters to T_PWRUP=20, T_SU=2, T_EH=4, T_HD=2, T_NIB=5, T_BYTE=10, T_LONG=40, T_INIT1=30, T_INIT2=15.
- Reset then run: E pulses carry nibbles 3,3,3,2,2,8,0,6,0,C,0,1 in order, all RS=0, each E high exactly 4 cycles; the first E rises 23 cycles after clear falls; init_done rises after the final T_LONG.
- After init, send wr_rs=1, wr_data=0x41: nibbles 4 then 1 with RS=1, 5 idle cycles between the strobes, then wr_ready returns 10 cycles after the second HOLD.
- Send rs=0, data=0x01 and compare with rs=1, data=0x01: the post-delays are 40 and 10 cycles respectively.
- Assert clear while E=1 mid-byte: on the next edge E=0, wr_ready=0, init_done=0, and the init sequence restarts from PWRUP.
- With LCD_CMD_FIFO_EN defined: push 5 bytes back-to-back during init; wr_ready falls after the 4th push; all bytes are emitted in order after init, and the 5th is accepted once the first pop frees a slot.
